// File: rtl/tang_uart_pkg.sv
// Shared UART definitions: receiver FSM states and the default bit period
// used by both the transmitter and the receiver.
package tang_uart_pkg;

   // 27 MHz / 115200 baud
   localparam int unsigned CLKS_PER_BIT_DEF = 234;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/tang_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable
// reset value so an idle-high line does not look like a start edge.
module tang_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         o_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         o_q    <= r_meta;
      end
   end

endmodule

// File: rtl/tang_uart_rx.sv
// 8N1 UART receiver: start-bit centring, LSB-first data capture, one-byte
// holding register with valid/ready handoff, framing-error and overrun pulses.
module tang_uart_rx
   import tang_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       SYS_CLK,
   input  logic       SYS_RST_N,
   input  logic       RX_IN,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   input  logic       RX_READY,
   output logic       RX_BUSY,
   output logic       RX_FRAME_ERR,
   output logic       RX_OVERRUN
);

   localparam int unsigned TW        = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

   logic            w_rxs;
   rx_state_t       r_state,   w_state_next;
   logic [TW-1:0]   r_timer,   w_timer_next;
   logic [2:0]      r_bit_idx, w_bit_idx_next;
   logic [7:0]      r_shift,   w_shift_next;
   logic [7:0]      w_data_next;
   logic            w_valid_next;
   logic            w_ferr_next;
   logic            w_ovr_next;
   logic            w_tick;

   tang_sync2 #(
      .RST_VAL (1'b1)
   ) u_sync (
      .i_clk   (SYS_CLK),
      .i_rst_n (SYS_RST_N),
      .i_d     (RX_IN),
      .o_q     (w_rxs)
   );

   assign w_tick = (r_timer == '0);

   // State, timing and holding-register flops
   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         r_state      <= IDLE;
         r_timer      <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         RX_DATA      <= '0;
         RX_VALID     <= 1'b0;
         RX_BUSY      <= 1'b0;
         RX_FRAME_ERR <= 1'b0;
         RX_OVERRUN   <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_timer      <= w_timer_next;
         r_bit_idx    <= w_bit_idx_next;
         r_shift      <= w_shift_next;
         RX_DATA      <= w_data_next;
         RX_VALID     <= w_valid_next;
         RX_BUSY      <= (w_state_next != IDLE);
         RX_FRAME_ERR <= w_ferr_next;
         RX_OVERRUN   <= w_ovr_next;
      end
   end

   // Next-state and output decode
   always_comb begin
      w_state_next   = r_state;
      w_timer_next   = r_timer;
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      w_data_next    = RX_DATA;
      w_valid_next   = RX_VALID & ~RX_READY;
      w_ferr_next    = 1'b0;
      w_ovr_next     = 1'b0;

      case (r_state)
         IDLE: begin
            if (!w_rxs) begin
               w_timer_next = HALF_LOAD;
               w_state_next = START;
            end
         end

         START: begin
            if (!w_tick) begin
               w_timer_next = r_timer - TW'(1);
            end else if (w_rxs) begin
               w_state_next = IDLE;
            end else begin
               w_timer_next   = FULL_LOAD;
               w_bit_idx_next = '0;
               w_state_next   = DATA;
            end
         end

         DATA: begin
            if (!w_tick) begin
               w_timer_next = r_timer - TW'(1);
            end else begin
               w_shift_next = {w_rxs, r_shift[7:1]};
               w_timer_next = FULL_LOAD;
               if (r_bit_idx == 3'd7) begin
                  w_state_next = STOP;
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
               end
            end
         end

         STOP: begin
            if (!w_tick) begin
               w_timer_next = r_timer - TW'(1);
            end else if (w_rxs) begin
               // An accept on this same edge frees the slot for the new byte
               if (!RX_VALID || RX_READY) begin
                  w_data_next  = r_shift;
                  w_valid_next = 1'b1;
               end else begin
                  w_ovr_next = 1'b1;
               end
               w_state_next = IDLE;
            end else begin
               w_ferr_next  = 1'b1;
               w_state_next = WAIT_IDLE;
            end
         end

         WAIT_IDLE: begin
            if (w_rxs) begin
               w_state_next = IDLE;
            end
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

endmodule
